// File: rtl/axil_acc_regs.sv
// AXI4-Lite control/status register block for the accelerator engines: CTRL with start
// pulse, W1C done/err status, IRQ enable, and NUM_CFG byte-strobed config registers.
`timescale 1ns/1ps

// One config register; wmask carries the byte-lane strobes expanded to bits.
module axil_acc_cfg_reg #(
  parameter int CFG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [CFG_W-1:0] wdata,
  input  logic [CFG_W-1:0] wmask,
  output logic [CFG_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= (q & ~wmask) | (wdata & wmask);
  end
endmodule

module axil_acc_regs #(
  parameter int NUM_CFG = 8,
  parameter int CFG_W   = 16,
  parameter int ADDR_W  = 12
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [2:0]               ctrl_o,
  output logic                     start_o,
  output logic [NUM_CFG*CFG_W-1:0] cfg_o,
  input  logic                     busy_i,
  input  logic                     done_i,
  output logic                     irq_o
);
  localparam int WIDX_W = ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WDAT, WADR, WRSP, RDEC, RRSP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        strb;
  } wreq_t;

  state_t                          state_q, state_d;
  logic [ADDR_W-1:0]               aw_addr_q, ar_addr_q;
  logic [31:0]                     w_data_q;
  logic [3:0]                      w_strb_q;
  wreq_t                           wr;
  logic                            wr_commit;
  logic [1:0]                      bresp_q, rresp_q;
  logic [31:0]                     rdata_q, rd_data;

  logic [2:0]                      ctrl_q;
  logic                            start_q, done_q, err_q, irq_en_q, irq_q;
  logic [NUM_CFG-1:0][CFG_W-1:0]   cfg_q;

  logic [WIDX_W-1:0]               wr_word, rd_word;
  logic                            wr_ctrl, wr_stat, wr_irqen, wr_mapped;
  logic                            rd_ctrl, rd_stat, rd_irqen, rd_mapped;
  logic [NUM_CFG-1:0]              wr_cfg_hit, rd_cfg_hit;
  logic [31:0]                     wmask;
  logic                            start_req, w1c;

  // FSM: state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // FSM: next state and write commit; the commit picks live or captured halves
  always_comb begin
    state_d   = state_q;
    wr_commit = 1'b0;
    wr.addr   = aw_addr_q;
    wr.data   = w_data_q;
    wr.strb   = w_strb_q;
    case (state_q)
      IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID) begin
          wr_commit = 1'b1;
          wr.addr   = S_AXI_AWADDR;
          wr.data   = S_AXI_WDATA;
          wr.strb   = S_AXI_WSTRB;
          state_d   = WRSP;
        end else if (S_AXI_AWVALID) state_d = WDAT;
        else if (S_AXI_WVALID)      state_d = WADR;
        else if (S_AXI_ARVALID)     state_d = RDEC;
      end
      WDAT: if (S_AXI_WVALID) begin
        wr_commit = 1'b1;
        wr.data   = S_AXI_WDATA;
        wr.strb   = S_AXI_WSTRB;
        state_d   = WRSP;
      end
      WADR: if (S_AXI_AWVALID) begin
        wr_commit = 1'b1;
        wr.addr   = S_AXI_AWADDR;
        state_d   = WRSP;
      end
      WRSP:    if (S_AXI_BREADY) state_d = IDLE;
      RDEC:    state_d = RRSP;
      RRSP:    if (S_AXI_RREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign S_AXI_AWREADY = (state_q == IDLE) || (state_q == WADR);
  assign S_AXI_WREADY  = (state_q == IDLE) || (state_q == WDAT);
  assign S_AXI_ARREADY = (state_q == IDLE);
  assign S_AXI_BVALID  = (state_q == WRSP);
  assign S_AXI_RVALID  = (state_q == RRSP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  // Channel capture for split AW/W arrivals and the read address
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
    end else if (state_q == IDLE) begin
      if (S_AXI_AWVALID) aw_addr_q <= S_AXI_AWADDR;
      if (S_AXI_WVALID) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (S_AXI_ARVALID) ar_addr_q <= S_AXI_ARADDR;
    end
  end

  // Address decode (word granularity)
  assign wr_word   = wr.addr[ADDR_W-1:2];
  assign rd_word   = ar_addr_q[ADDR_W-1:2];
  assign wr_ctrl   = (wr_word == WIDX_W'(0));
  assign wr_stat   = (wr_word == WIDX_W'(1));
  assign wr_irqen  = (wr_word == WIDX_W'(2));
  assign rd_ctrl   = (rd_word == WIDX_W'(0));
  assign rd_stat   = (rd_word == WIDX_W'(1));
  assign rd_irqen  = (rd_word == WIDX_W'(2));
  assign wr_mapped = wr_ctrl || wr_stat || wr_irqen || (|wr_cfg_hit);
  assign rd_mapped = rd_ctrl || rd_stat || rd_irqen || (|rd_cfg_hit);

  assign wmask = {{8{wr.strb[3]}}, {8{wr.strb[2]}}, {8{wr.strb[1]}}, {8{wr.strb[0]}}};

  for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg
    assign wr_cfg_hit[i] = (wr_word == WIDX_W'(4 + i));
    assign rd_cfg_hit[i] = (rd_word == WIDX_W'(4 + i));
    axil_acc_cfg_reg #(.CFG_W(CFG_W)) u_cfg (
      .clk   (S_AXI_ACLK),
      .rst_n (S_AXI_ARESETN),
      .we    (wr_commit && wr_cfg_hit[i]),
      .wdata (wr.data[CFG_W-1:0]),
      .wmask (wmask[CFG_W-1:0]),
      .q     (cfg_q[i])
    );
  end

  assign start_req = wr_commit && wr_ctrl && wr.strb[1] && wr.data[8];
  assign w1c       = wr_commit && wr_stat && wr.strb[0];

  // Control/status state; a concurrent hardware set beats a W1C clear
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (wr_commit && wr_ctrl && wr.strb[0])  ctrl_q   <= wr.data[2:0];
      if (wr_commit && wr_irqen && wr.strb[0]) irq_en_q <= wr.data[0];
      start_q <= start_req && !busy_i;
      if (done_i)                  done_q <= 1'b1;
      else if (w1c && wr.data[1])  done_q <= 1'b0;
      if (start_req && busy_i)     err_q  <= 1'b1;
      else if (w1c && wr.data[2])  err_q  <= 1'b0;
      irq_q <= done_q && irq_en_q;
      if (wr_commit) bresp_q <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_ctrl)  rd_data[2:0] = ctrl_q;
    if (rd_stat)  rd_data[2:0] = {err_q, done_q, busy_i};
    if (rd_irqen) rd_data[0]   = irq_en_q;
    for (int i = 0; i < NUM_CFG; i++)
      if (rd_cfg_hit[i]) rd_data[CFG_W-1:0] = cfg_q[i];
  end

  // Read data is captured once in RDEC and held through RRSP
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (state_q == RDEC) begin
      rdata_q <= rd_data;
      rresp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign start_o = start_q;
  assign cfg_o   = cfg_q;
  assign irq_o   = irq_q;

  logic unused_bits;
  assign unused_bits = ^{wr.data, wr.addr[1:0], ar_addr_q[1:0]};
endmodule

// File: tb/tb_axil_acc_regs.sv
// Directed bench for axil_acc_regs: reset, write paths, strobes, start/err, IRQ, SLVERR, reset abort.
`timescale 1ns/1ps

module tb_axil_acc_regs;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [11:0]  awaddr = '0, araddr = '0;
  logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [2:0]   ctrl_o;
  logic         start_o, irq_o;
  logic [127:0] cfg_o;
  logic         busy_i = 0, done_i = 0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  axil_acc_regs #(.NUM_CFG(8), .CFG_W(16), .ADDR_W(12)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_o(ctrl_o), .start_o(start_o), .cfg_o(cfg_o),
    .busy_i(busy_i), .done_i(done_i), .irq_o(irq_o)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Bus drivers; each starts and ends 1ns after a rising edge.
  task automatic axi_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [1:0] resp);
    int  n = 0;
    bit  aw_hs, w_hs;
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick(); n++;
      if (aw_hs) awvalid = 0;
      if (w_hs)  wvalid = 0;
    end
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    if (!bvalid) begin
      tests_run++; tests_failed++;
      $display("FAIL axi_wr timeout addr=%h", a);
      awvalid = 0; wvalid = 0;
    end
    resp = bresp;
    bready = 1; tick(); bready = 0;
  endtask

  task automatic axi_rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp,
                        output int lat);
    int n = 0;
    araddr = a; arvalid = 1;
    while (!arready && n < 20) begin tick(); n++; end
    tick(); arvalid = 0; lat = 1;
    while (!rvalid && lat < 20) begin tick(); lat++; end
    if (!rvalid) begin
      tests_run++; tests_failed++;
      $display("FAIL axi_rd timeout addr=%h", a);
    end
    d = rdata; resp = rresp;
    rready = 1; tick(); rready = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int lat;
    logic [11:0] addrs [4] = '{12'h000, 12'h004, 12'h008, 12'h010};
    rst_n = 0; repeat (3) tick(); rst_n = 1; tick();
    tests_run++;
    if (ctrl_o !== 3'b000 || start_o !== 1'b0 || irq_o !== 1'b0 || cfg_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ctrl=%b start=%b irq=%b cfg=%h, want all 0", ctrl_o, start_o, irq_o, cfg_o);
    end
    foreach (addrs[i]) begin
      axi_rd(addrs[i], d, r, lat);
      tests_run++;
      if (d !== 32'h0 || r !== 2'b00) begin
        tests_failed++;
        $display("FAIL reset_read %h: data=%h resp=%b, want 0/00", addrs[i], d, r);
      end
    end
  endtask

  task automatic test_aw_w_same();
    logic [31:0] d; logic [1:0] r; int lat;
    awaddr = 12'h010; wdata = 32'h0000ABCD; wstrb = 4'b0011; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || cfg_o[15:0] !== 16'hABCD) begin
      tests_failed++;
      $display("FAIL same_cycle_write: bvalid=%b bresp=%b cfg0=%h, want 1/00/abcd", bvalid, bresp, cfg_o[15:0]);
    end
    bready = 1; tick(); bready = 0;
    tests_run++;
    if (bvalid !== 1'b0) begin
      tests_failed++; $display("FAIL bvalid_drop: got %b want 0", bvalid);
    end
    axi_rd(12'h010, d, r, lat);
    tests_run++;
    if (d !== 32'h0000ABCD || r !== 2'b00 || lat !== 2) begin
      tests_failed++;
      $display("FAIL cfg0_readback: data=%h resp=%b lat=%0d, want 0000abcd/00/2", d, r, lat);
    end
  endtask

  task automatic test_w_first_strobe();
    logic [31:0] d; logic [1:0] r; int lat;
    bit held_ok = 1;
    axi_wr(12'h014, 32'h00001234, 4'b0011, r);
    wdata = 32'h000056AB; wstrb = 4'b0001; wvalid = 1;
    tick(); wvalid = 0;
    tick(); tick();
    tests_run++;
    if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wadr_wait: awready=%b wready=%b bvalid=%b, want 1/0/0", awready, wready, bvalid);
    end
    awaddr = 12'h014; awvalid = 1;
    tick(); awvalid = 0;
    tests_run++;
    if (bvalid !== 1'b1 || cfg_o[31:16] !== 16'h12AB) begin
      tests_failed++;
      $display("FAIL w_first_strobe: bvalid=%b cfg1=%h, want 1/12ab", bvalid, cfg_o[31:16]);
    end
    araddr = 12'h010; arvalid = 1;
    repeat (4) begin
      tick();
      if (bvalid !== 1'b1 || arready !== 1'b0) held_ok = 0;
    end
    tests_run++;
    if (!held_ok) begin
      tests_failed++; $display("FAIL bresp_hold: bvalid/arready changed while bready low, want 1/0");
    end
    arvalid = 0; bready = 1; tick(); bready = 0;
    axi_rd(12'h014, d, r, lat);
    tests_run++;
    if (d !== 32'h000012AB || r !== 2'b00) begin
      tests_failed++; $display("FAIL cfg1_readback: data=%h resp=%b, want 000012ab/00", d, r);
    end
  endtask

  task automatic test_ctrl_start();
    logic [31:0] d; logic [1:0] r; int lat;
    busy_i = 0;
    awaddr = 12'h000; wdata = 32'h00000103; wstrb = 4'b0011; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    tests_run++;
    if (ctrl_o !== 3'b011 || start_o !== 1'b1) begin
      tests_failed++; $display("FAIL start_pulse: ctrl=%b start=%b, want 011/1", ctrl_o, start_o);
    end
    bready = 1; tick(); bready = 0;
    tests_run++;
    if (start_o !== 1'b0) begin
      tests_failed++; $display("FAIL start_width: start=%b one cycle later, want 0", start_o);
    end
    axi_rd(12'h000, d, r, lat);
    tests_run++;
    if (d !== 32'h00000003) begin
      tests_failed++; $display("FAIL ctrl_readback: data=%h want 00000003", d);
    end
    busy_i = 1;
    awaddr = 12'h000; wdata = 32'h00000105; wstrb = 4'b0011; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    tests_run++;
    if (ctrl_o !== 3'b101 || start_o !== 1'b0) begin
      tests_failed++; $display("FAIL start_busy: ctrl=%b start=%b, want 101/0", ctrl_o, start_o);
    end
    bready = 1; tick(); bready = 0;
    axi_rd(12'h004, d, r, lat);
    tests_run++;
    if (d !== 32'h00000005) begin
      tests_failed++; $display("FAIL status_err_busy: data=%h want 00000005", d);
    end
    busy_i = 0;
    awaddr = 12'h000; wdata = 32'h00000102; wstrb = 4'b0001; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    tests_run++;
    if (start_o !== 1'b0 || ctrl_o !== 3'b010) begin
      tests_failed++; $display("FAIL start_no_lane1: start=%b ctrl=%b, want 0/010", start_o, ctrl_o);
    end
    bready = 1; tick(); bready = 0;
    axi_wr(12'h004, 32'h00000004, 4'b0001, r);
    axi_rd(12'h004, d, r, lat);
    tests_run++;
    if (d !== 32'h00000000) begin
      tests_failed++; $display("FAIL err_w1c: status=%h want 00000000", d);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_wr(12'h008, 32'h00000001, 4'b0001, r);
    done_i = 1; tick(); done_i = 0;
    tick();
    tests_run++;
    if (irq_o !== 1'b1) begin
      tests_failed++; $display("FAIL irq_set: irq=%b want 1", irq_o);
    end
    awaddr = 12'h004; wdata = 32'h00000002; wstrb = 4'b0001; awvalid = 1; wvalid = 1; done_i = 1;
    tick(); awvalid = 0; wvalid = 0; done_i = 0;
    bready = 1; tick(); bready = 0;
    axi_rd(12'h004, d, r, lat);
    tests_run++;
    if (d !== 32'h00000002 || irq_o !== 1'b1) begin
      tests_failed++; $display("FAIL done_set_wins: status=%h irq=%b, want 00000002/1", d, irq_o);
    end
    axi_wr(12'h004, 32'h00000002, 4'b0010, r);
    axi_rd(12'h004, d, r, lat);
    tests_run++;
    if (d !== 32'h00000002) begin
      tests_failed++; $display("FAIL w1c_lane_gate: status=%h want 00000002", d);
    end
    axi_wr(12'h004, 32'h00000002, 4'b0001, r);
    tests_run++;
    if (irq_o !== 1'b0) begin
      tests_failed++; $display("FAIL irq_clear: irq=%b want 0", irq_o);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_rd(12'h3FC, d, r, lat);
    tests_run++;
    if (d !== 32'h0 || r !== 2'b10) begin
      tests_failed++; $display("FAIL unmapped_read: data=%h resp=%b, want 0/10", d, r);
    end
    axi_wr(12'h200, 32'hFFFFFFFF, 4'b1111, r);
    tests_run++;
    if (r !== 2'b10 || cfg_o[31:0] !== 32'h12ABABCD || ctrl_o !== 3'b010) begin
      tests_failed++;
      $display("FAIL unmapped_write: bresp=%b cfg01=%h ctrl=%b, want 10/12ababcd/010", r, cfg_o[31:0], ctrl_o);
    end
    axi_wr(12'h030, 32'h0000FFFF, 4'b1111, r);
    tests_run++;
    if (r !== 2'b10) begin
      tests_failed++; $display("FAIL past_last_cfg: bresp=%b want 10", r);
    end
    axi_wr(12'h02C, 32'h0000BEEF, 4'b1111, r);
    tests_run++;
    if (r !== 2'b00 || cfg_o[127:112] !== 16'hBEEF) begin
      tests_failed++; $display("FAIL last_cfg: bresp=%b cfg7=%h, want 00/beef", r, cfg_o[127:112]);
    end
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    araddr = 12'h010; arvalid = 1;
    tick(); arvalid = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    tests_run++;
    if (rvalid !== 1'b1) begin
      tests_failed++; $display("FAIL rrsp_reach: rvalid=%b want 1", rvalid);
    end
    #2 rst_n = 0;
    #1;
    tests_run++;
    if (rvalid !== 1'b0 || cfg_o !== '0) begin
      tests_failed++; $display("FAIL async_reset: rvalid=%b cfg=%h, want 0/0", rvalid, cfg_o);
    end
    tick(); rst_n = 1; tick();
  endtask

  initial begin
    test_reset();
    test_aw_w_same();
    test_w_first_strobe();
    test_ctrl_start();
    test_irq();
    test_unmapped();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/axil_acc_regs.md
Name: axil_acc_regs

Overview:
- Parametrised AXI4-Lite slave control/status register block for the accelerator family.
- Successor to the fixed six-register decoder embedded in the current accelerator top, adding:
  - parameterised config register count and width
  - WSTRB byte-lane handling
  - SLVERR on unmapped addresses
  - a self-clearing start pulse
  - W1C done/error status
  - an interrupt output
- Sits between the PS AXI-Lite port and the batch/execution controllers.

Parameters:
- NUM_CFG, 8: number of config registers at 0x010 + 4*i (1..32).
- CFG_W, 16: implemented bits per config register (1..32). Upper bits read 0, writes ignored.
- ADDR_W, 12: decoded AXI address width. Bits [1:0] are ignored.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  reset
- S_AXI_AWADDR  in  ADDR_W  write address
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4 / S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  ADDR_W / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1
- ctrl_o  out  3  {last, run, matw}
- start_o  out  1  one-cycle start pulse
- cfg_o  out  NUM_CFG*CFG_W  config registers, reg i at bits [i*CFG_W +: CFG_W]
- busy_i  in  1  engine busy
- done_i  in  1  engine completion pulse
- irq_o  out  1  level interrupt

Behaviour:
- Clocking and reset: one clock, S_AXI_ACLK. Reset S_AXI_ARESETN is asynchronous, active-low. All registers and outputs reset to 0. FSM resets to IDLE.
- Register map:
  - 0x000 CTRL RW: [2:0] {last, run, matw}; [8] start, write-1 generates pulse, always reads 0.
  - 0x004 STATUS: [0] busy, read-only live busy_i; [1] done, W1C; [2] err, W1C.
  - 0x008 IRQ_EN RW: [0] enable.
  - 0x010 + 4*i: CFG i, RW, CFG_W bits.
  - Any other address: unmapped. Write is discarded, read returns 0, response is SLVERR (2'b10). Mapped accesses return OKAY (2'b00).
- Byte strobes: only byte lanes with WSTRB set are updated. A W1C bit is cleared only if its lane strobe is set.
- FSM states: IDLE, WDAT (have addr, wait W), WADR (have data, wait AW), WRSP, RDEC, RRSP.
  - AWREADY=1 in IDLE and WADR.
  - WREADY=1 in IDLE and WDAT.
  - ARREADY=1 in IDLE only.
  - BVALID=1 in WRSP.
  - RVALID=1 in RRSP.
- Transitions:
  - IDLE with AW and W both valid: go to WRSP. Write commits on this same edge.
  - IDLE with only AW valid: go to WDAT.
  - IDLE with only W valid: go to WADR.
  - IDLE with AR valid and no AW/W: go to RDEC. Writes have priority over reads.
  - WDAT/WADR: when the missing channel is valid, commit the write and go to WRSP.
  - WRSP: return to IDLE when BREADY=1.
  - RDEC: register RDATA/RRESP, go to RRSP.
  - RRSP: hold RDATA/RRESP stable until RREADY=1, then go to IDLE.
- Latency:
  - Write: register value is visible on cfg_o/ctrl_o in the first cycle BVALID is high.
  - Read: RVALID asserts 2 cycles after the AR handshake.
- start_o:
  - A write to CTRL with lane 1 strobed, bit 8 = 1, and busy_i = 0 produces start_o = 1 for exactly the one cycle after commit.
  - If busy_i = 1 at commit, no pulse is generated and err is set. The {last, run, matw} fields are still written.
- done bit:
  - done_i = 1 sets done.
  - If a set and a W1C clear occur in the same cycle, the set wins. The same rule applies to err.
- irq_o = done & irq_en. It is registered, one cycle after either input changes, and stays high until done is cleared or enable is cleared.
- Reset asserted mid-transaction: the FSM goes to IDLE immediately and any pending B/R response is dropped. No partial write occurs unless the commit edge has already passed.
- busy_i and done_i are synchronous to S_AXI_ACLK. No CDC is performed inside this block.

Test Plan:
1. Reset, then read 0x000..0x008 and CFG0 -> all RDATA=0, RRESP=OKAY. Outputs ctrl_o=0, start_o=0, irq_o=0.
2. AW and W in the same cycle: 0x010, 0x0000ABCD, WSTRB=4'b0011 -> BVALID next cycle. cfg_o[15:0]=16'hABCD that cycle. Readback returns 0x0000ABCD with RVALID 2 cycles after AR.
3. W presented 3 cycles before AW, target 0x014 with WSTRB=4'b0001 over prior value 0x1234 -> CFG1=0x12xx, only the low byte changes. Then BREADY held low 4 cycles -> BVALID stays high; FSM does not accept AR.
4. Write 0x00000103 to CTRL with busy_i=0 -> ctrl_o=3'b011, start_o high for exactly 1 cycle. Repeat with busy_i=1 -> no pulse, STATUS reads 0x5 (err, busy).
5. IRQ_EN=1, pulse done_i -> irq_o=1 one cycle later. Write 0x2 to STATUS in the same cycle as a second done_i pulse -> done stays 1. Next W1C of 0x2 -> irq_o=0.
6. Read 0x3FC and write 0x200 -> RRESP/BRESP=2'b10, RDATA=0, no register changes. Assert reset while in RRSP -> RVALID drops asynchronously.
